trng_word_collector: RTL and testbench
======================================

Name: trng_word_collector

Overview:
- Consumer end of the TRNG serial stream: samples `random_bit` whenever `random_valid` is high.
- Optional von Neumann debiasing, then packs bits MSB-first into WORD_W-bit words.
- Presents each word on a valid/ready handshake to downstream logic (CSR or FIFO).
- Runs a repetition-count health test on the raw bits and blocks output on failure.

Parameters:
- WORD_W, 32, output word width in bits (>=2).
- REP_LIMIT, 16, number of consecutive identical raw bits that trips the health test (>=2).
- DEBIAS, 1, 1 = von Neumann debiasing enabled; 0 = raw bits packed directly.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  collection enable; raw bits are ignored while low.
- random_bit  in  1  raw entropy bit.
- random_valid  in  1  qualifies random_bit for one cycle.
- word_ready  in  1  downstream accepts word_data this cycle.
- clear_fail  in  1  one-cycle pulse that clears a latched health failure.
- word_data  out  WORD_W  assembled random word, stable while word_valid is high.
- word_valid  out  1  a word is held for output.
- health_fail  out  1  sticky repetition-test failure flag.
- drop_cnt  out  16  saturating count of completed words lost to a full hold register.

Behaviour:
- Reset (rst=1 at an edge) values:
  - Outputs: word_data=0, word_valid=0, health_fail=0, drop_cnt=0.
  - Internal: bit count=0, pair state empty, rep count=0, last bit=0, state=RUN.
- Raw accept: a bit is accepted in a cycle with enable && random_valid && state==RUN.
- Health test (raw bits, before debias):
  - Accepted bit equal to last bit: rep count increments. Otherwise rep count=1 and last bit is updated.
  - The first bit after reset or after a clear also sets rep count=1.
  - Rep count reaching REP_LIMIT:
    - State goes to FAIL next cycle; health_fail=1.
    - The shifter, bit count, pair state and hold register are cleared; word_valid=0.
    - The bit that trips the test is never packed.
- FAIL:
  - All raw bits are ignored and word_valid stays 0.
  - A clear_fail pulse returns to RUN: health_fail=0, rep count=0, pair state empty. drop_cnt is kept.
  - clear_fail in RUN has no effect.
- Debias (DEBIAS=1):
  - Accepted bits are taken in pairs.
  - Pairs 01 and 10 emit the first bit of the pair (01 gives 0, 10 gives 1).
  - Pairs 00 and 11 emit nothing.
  - Emission happens in the same cycle the second bit is accepted.
- Debias off (DEBIAS=0): every accepted bit is emitted.
- Packing: an emitted bit shifts into the LSB of the shifter (the first bit ends at the MSB). The bit count increments and wraps at WORD_W.
- Word completion (the emitted bit makes the count WORD_W):
  - Hold register empty, or word_ready && word_valid in the same cycle: the word loads into word_data, and word_valid=1 next cycle.
  - A handshake coinciding with completion keeps word_valid high with the new data.
  - Otherwise the word is discarded and drop_cnt increments, saturating at 16'hFFFF.
  - In both cases the bit count restarts at 0.
- Latency: word_valid rises 1 cycle after the accepting edge of the completing bit.
- Handshake:
  - word_valid && word_ready at an edge clears word_valid (unless a new word loads in that cycle).
  - word_data is held while word_valid=1 and not accepted.
- enable low:
  - Discards the partial word and clears pair state at the first low cycle.
  - The hold register, rep count and last bit are retained.
- rst mid-word or mid-handshake: all state returns to reset values at that edge; the held word is lost.
- Arithmetic:
  - Bit count width: $clog2(WORD_W+1).
  - Rep count width: $clog2(REP_LIMIT+1); it never exceeds REP_LIMIT.

Decomposition:
- Shared package trng_pkg:
  - State enum with values RUN and FAIL.
  - DROP_CNT_W=16 and the default WORD_W/REP_LIMIT constants.
- Sub-module trng_vn_debias holds the pair register and emit logic (in: bit and valid; out: bit and valid). It is bypassed by a generate block when DEBIAS=0.
- Packing, health test and handshake stay in the top module.

Test Plan:
- WORD_W=8, DEBIAS=0: feed raw bits 1,0,1,1,0,0,1,0 with word_ready=1 -> word_valid pulses 1 cycle after the 8th bit, word_data=8'hB2, drop_cnt=0.
- WORD_W=8, DEBIAS=1: raw pairs 01,10,11,10,00,01,10,10,10,01 -> emitted 0,1,1,0,1,1,1,0, word_data=8'h6E.
- WORD_W=8, DEBIAS=0, word_ready=0: 24 alternating bits (10 repeated) -> word_data=8'hAA held, drop_cnt=2. Then word_ready=1 -> word_valid falls next cycle.
- REP_LIMIT=4, DEBIAS=0: raw 0,1,1,1,1 -> health_fail=1 the cycle after the 5th bit and word_valid=0. Further bits are ignored. A clear_fail pulse gives health_fail=0, and a fresh word then completes normally.
- WORD_W=8, DEBIAS=0: enable drops after 5 bits, then returns, then 8 bits of 0x5A -> word_data=8'h5A, i.e. the partial word was discarded.
- Held word present and rst asserted for 1 cycle -> word_valid=0, word_data=0, drop_cnt=0, health_fail=0.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG word collector.
// The run/fail state is shared by the collector and by any CSR logic that reports it.
package trng_pkg;

   typedef enum logic {
      RUN  = 1'b0,
      FAIL = 1'b1
   } state_t;

   localparam int DROP_CNT_W    = 16;
   localparam int DEF_WORD_W    = 32;
   localparam int DEF_REP_LIMIT = 16;

endpackage

// File: rtl/trng_vn_debias.sv
// Von Neumann debiaser: takes raw bits in pairs, emits the first bit of 01/10 pairs.
// Emission is combinational with the second bit of the pair; flush empties the pair register.
module trng_vn_debias (
   input  logic clk,
   input  logic rst,
   input  logic flush,
   input  logic in_bit,
   input  logic in_valid,
   output logic out_bit,
   output logic out_valid
);

   logic have_first;
   logic first_bit;

   assign out_bit   = first_bit;
   assign out_valid = in_valid && have_first && (first_bit != in_bit);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         have_first <= 1'b0;
         first_bit  <= 1'b0;
      end else if (in_valid) begin
         have_first <= !have_first;
         if (!have_first)
            first_bit <= in_bit;
      end
   end

endmodule

// File: rtl/trng_word_collector.sv
// Collects TRNG raw bits, optionally debiases them, packs MSB-first words and offers them
// on a valid/ready handshake while a repetition-count health test guards the raw stream.
module trng_word_collector
   import trng_pkg::*;
#(
   parameter int WORD_W    = DEF_WORD_W,
   parameter int REP_LIMIT = DEF_REP_LIMIT,
   parameter bit DEBIAS    = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  random_bit,
   input  logic                  random_valid,
   input  logic                  word_ready,
   input  logic                  clear_fail,
   output logic [WORD_W-1:0]     word_data,
   output logic                  word_valid,
   output logic                  health_fail,
   output logic [DROP_CNT_W-1:0] drop_cnt
);

   localparam int CNT_W = $clog2(WORD_W + 1);
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   state_t            state;
   state_t            state_next;
   logic [WORD_W-1:0] shifter;
   logic [CNT_W-1:0]  bit_cnt;
   logic [REP_W-1:0]  rep_cnt;
   logic              last_bit;

   logic              accept;
   logic              rep_match;
   logic [REP_W-1:0]  rep_next;
   logic              trip;
   logic              pair_clear;
   logic              deb_bit;
   logic              deb_valid;
   logic              emit;
   logic [WORD_W-1:0] shift_in;
   logic [CNT_W-1:0]  cnt_inc;
   logic              word_done;
   logic              hold_free;

   assign accept    = enable && random_valid && (state == RUN);
   // An empty rep count means no reference bit yet, so the first bit always restarts the run.
   assign rep_match = (rep_cnt != '0) && (random_bit == last_bit);
   assign rep_next  = rep_match ? rep_cnt + 1'b1 : REP_W'(1);
   assign trip      = accept && (rep_next == REP_W'(REP_LIMIT));
   assign pair_clear = !enable || trip || (state == FAIL);

   generate
      if (DEBIAS) begin : g_debias
         trng_vn_debias u_debias (
            .clk       (clk),
            .rst       (rst),
            .flush     (pair_clear),
            .in_bit    (random_bit),
            .in_valid  (accept),
            .out_bit   (deb_bit),
            .out_valid (deb_valid)
         );
      end else begin : g_raw
         assign deb_bit   = random_bit;
         assign deb_valid = accept;
      end
   endgenerate

   // The tripping bit must never reach the shifter.
   assign emit      = deb_valid && !trip;
   assign shift_in  = {shifter[WORD_W-2:0], deb_bit};
   assign cnt_inc   = bit_cnt + 1'b1;
   assign word_done = emit && (cnt_inc == CNT_W'(WORD_W));
   assign hold_free = !word_valid || word_ready;

   assign health_fail = (state == FAIL);

   // NOTE: default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_next = state;
      if (state == RUN) begin
         if (trip)
            state_next = FAIL;
      end else if (clear_fail) begin
         state_next = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= RUN;
      else
         state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rep_cnt  <= '0;
         last_bit <= 1'b0;
      end else if (state == FAIL) begin
         if (clear_fail)
            rep_cnt <= '0;
      end else if (accept) begin
         rep_cnt <= rep_next;
         if (!rep_match)
            last_bit <= random_bit;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || !enable || trip || (state == FAIL)) begin
         shifter <= '0;
         bit_cnt <= '0;
      end else if (emit) begin
         shifter <= shift_in;
         bit_cnt <= word_done ? '0 : cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         word_data  <= '0;
         word_valid <= 1'b0;
         drop_cnt   <= '0;
      end else if (trip) begin
         word_data  <= '0;
         word_valid <= 1'b0;
      end else if (word_done && hold_free) begin
         word_data  <= shift_in;
         word_valid <= 1'b1;
      end else begin
         if (word_done && (drop_cnt != {DROP_CNT_W{1'b1}}))
            drop_cnt <= drop_cnt + 1'b1;
         if (word_valid && word_ready)
            word_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_trng_word_collector.sv
// Bench for trng_word_collector: a raw-pack instance (REP_LIMIT=4) and a debiasing instance
// share stimulus; each is compared every cycle against a behavioural model of the stream.
module tb_trng_word_collector;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, enable, random_bit, random_valid, word_ready, clear_fail;
   logic [7:0]  a_data, b_data;
   logic        a_valid, b_valid, a_fail, b_fail;
   logic [15:0] a_drop, b_drop;

   int vectors     = 0;
   int miscompares = 0;

   typedef struct {
      bit fail;
      int rep;
      bit last;
      bit have;
      bit first;
      int cnt;
      int acc;
      bit valid;
      int data;
      int drop;
   } model_t;

   model_t ma, mb;

   trng_word_collector #(.WORD_W(8), .REP_LIMIT(4), .DEBIAS(1'b0)) dut_a (
      .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
      .random_valid(random_valid), .word_ready(word_ready), .clear_fail(clear_fail),
      .word_data(a_data), .word_valid(a_valid), .health_fail(a_fail), .drop_cnt(a_drop)
   );

   trng_word_collector #(.WORD_W(8), .REP_LIMIT(8), .DEBIAS(1'b1)) dut_b (
      .clk(clk), .rst(rst), .enable(enable), .random_bit(random_bit),
      .random_valid(random_valid), .word_ready(word_ready), .clear_fail(clear_fail),
      .word_data(b_data), .word_valid(b_valid), .health_fail(b_fail), .drop_cnt(b_drop)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock of the stream as seen by the consumer: health test on raw bits, pairing,
   // MSB-first packing into an integer word, single-entry hold with drop counting.
   task automatic model_step(inout model_t m, input int ww, input int rl, input bit db,
                             input bit r, input bit e, input bit b, input bit v,
                             input bit rd, input bit c);
      bit emit, ebit, loaded, hs;
      if (r) begin
         m = '{default: 0};
         return;
      end
      if (m.fail) begin
         if (c) begin
            m.fail = 0;
            m.rep  = 0;
         end
         return;
      end
      hs = m.valid && rd;
      emit = 0;
      ebit = 0;
      loaded = 0;
      if (!e) begin
         m.have = 0;
         m.cnt  = 0;
      end else if (v) begin
         if (m.rep > 0 && b == m.last) m.rep++;
         else begin
            m.rep  = 1;
            m.last = b;
         end
         if (m.rep == rl) begin
            m.fail = 1;
            m.have = 0;
            m.cnt = 0;
            m.valid = 0;
            m.data = 0;
            return;
         end
         if (!db) begin
            emit = 1;
            ebit = b;
         end else if (!m.have) begin
            m.have  = 1;
            m.first = b;
         end else begin
            m.have = 0;
            if (m.first != b) begin
               emit = 1;
               ebit = m.first;
            end
         end
      end
      if (emit) begin
         m.acc = (m.acc * 2 + int'(ebit)) % (1 << ww);
         m.cnt++;
         if (m.cnt == ww) begin
            m.cnt = 0;
            if (!m.valid || rd) begin
               m.data  = m.acc;
               m.valid = 1;
               loaded  = 1;
            end else if (m.drop < 65535) begin
               m.drop++;
            end
         end
      end
      if (hs && !loaded) m.valid = 0;
   endtask

   task automatic compare_all();
      check("a.word_valid", 32'(a_valid), 32'(ma.valid));
      check("a.word_data", 32'(a_data), 32'(ma.data));
      check("a.health_fail", 32'(a_fail), 32'(ma.fail));
      check("a.drop_cnt", 32'(a_drop), 32'(ma.drop));
      check("b.word_valid", 32'(b_valid), 32'(mb.valid));
      check("b.word_data", 32'(b_data), 32'(mb.data));
      check("b.health_fail", 32'(b_fail), 32'(mb.fail));
      check("b.drop_cnt", 32'(b_drop), 32'(mb.drop));
   endtask

   // Called at a falling edge: drive, advance models, clock, then compare at the next falling edge.
   task automatic cycle(input bit r, input bit e, input bit b, input bit v,
                        input bit rd, input bit c);
      rst = r;
      enable = e;
      random_bit = b;
      random_valid = v;
      word_ready = rd;
      clear_fail = c;
      model_step(ma, 8, 4, 1'b0, r, e, b, v, rd, c);
      model_step(mb, 8, 8, 1'b1, r, e, b, v, rd, c);
      @(posedge clk);
      @(negedge clk);
      compare_all();
   endtask

   task automatic feed_bits(input logic [31:0] bits, input int n, input bit rd);
      for (int i = n - 1; i >= 0; i--)
         cycle(1'b0, 1'b1, bits[i], 1'b1, rd, 1'b0);
   endtask

   task automatic idle(input bit rd);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, rd, 1'b0);
   endtask

   task automatic gap();
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      enable = 1'b0;
      random_bit = 1'b0;
      random_valid = 1'b0;
      word_ready = 1'b0;
      clear_fail = 1'b0;
      @(negedge clk);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("reset.word_valid", 32'(a_valid), 32'd0);
      check("reset.word_data", 32'(a_data), 32'd0);
      check("reset.health_fail", 32'(a_fail), 32'd0);
      check("reset.drop_cnt", 32'(b_drop), 32'd0);

      // Raw packing, word_ready held high.
      feed_bits(32'hB2, 8, 1'b1);
      check("raw.valid_after_8th", 32'(a_valid), 32'd1);
      check("raw.data_B2", 32'(a_data), 32'hB2);
      check("raw.drop_zero", 32'(a_drop), 32'd0);
      idle(1'b1);
      check("raw.valid_falls", 32'(a_valid), 32'd0);

      // Debias pairs 01,10,11,10,00,01,10,10,10,01 -> 0x6E (trips the REP_LIMIT=4 instance).
      gap();
      feed_bits(32'b01101110000110101001, 20, 1'b1);
      check("debias.valid", 32'(b_valid), 32'd1);
      check("debias.data_6E", 32'(b_data), 32'h6E);
      check("debias.a_tripped", 32'(a_fail), 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check("clear.a_fail", 32'(a_fail), 32'd0);

      // Hold register full: first word kept, later two dropped.
      for (int i = 0; i < 24; i++)
         cycle(1'b0, 1'b1, (i % 2) == 0, 1'b1, 1'b0, 1'b0);
      check("hold.data_AA", 32'(a_data), 32'hAA);
      check("hold.valid", 32'(a_valid), 32'd1);
      check("hold.drop_2", 32'(a_drop), 32'd2);
      idle(1'b1);
      check("hold.valid_falls", 32'(a_valid), 32'd0);

      // Repetition test: 0,1,1,1,1 trips at the 5th bit.
      gap();
      feed_bits(32'b01111, 5, 1'b1);
      check("rep.health_fail", 32'(a_fail), 32'd1);
      check("rep.word_valid", 32'(a_valid), 32'd0);
      feed_bits(32'b1010, 4, 1'b1);
      check("rep.still_fail", 32'(a_fail), 32'd1);
      check("rep.still_no_word", 32'(a_valid), 32'd0);
      cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("rep.cleared", 32'(a_fail), 32'd0);

      // Partial word discarded when enable drops.
      feed_bits(32'b11001, 5, 1'b1);
      gap();
      feed_bits(32'h5A, 8, 1'b1);
      check("enable.valid", 32'(a_valid), 32'd1);
      check("enable.data_5A", 32'(a_data), 32'h5A);
      idle(1'b1);

      // Reset while a word is held.
      feed_bits(32'h96, 8, 1'b0);
      check("rst.held_before", 32'(a_valid), 32'd1);
      cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("rst.word_valid", 32'(a_valid), 32'd0);
      check("rst.word_data", 32'(a_data), 32'd0);
      check("rst.drop_cnt", 32'(a_drop), 32'd0);
      check("rst.health_fail", 32'(a_fail), 32'd0);

      // Randomized traffic against the models.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0,
               $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
